// File: rtl/weight_noise_loader.sv
// Packs a 32-bit host word stream into wide rows and writes weight, threshold
// and noise rows to the row memory, then kicks off the matrix-loop stage.
module weight_noise_loader #(
  parameter int DATABITS         = 32,
  parameter int WORDS_PER_ROW    = 100,
  parameter int URAM_LEN         = 3200,
  parameter int NUM_ROWS         = 100,
  parameter int ADDR_BIT         = 11,
  parameter int TH_ADDR          = 1024,
  parameter int NOISE_START_ADDR = 1025,
  parameter int MAX_LOOPS        = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic [31:0]         load_loop_number,
  input  logic [DATABITS-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                wr_en,
  output logic [ADDR_BIT-1:0] wr_addr,
  output logic [URAM_LEN-1:0] wr_data,
  output logic                start_computation,
  output logic [31:0]         loop_number,
  output logic                busy,
  output logic                cfg_err
);

  localparam int WCNT_W = $clog2(WORDS_PER_ROW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_MAT,
    S_LD_TH,
    S_LD_NOISE,
    S_START
  } state_t;

  state_t              r_state;
  logic [WCNT_W-1:0]   r_word_cnt;
  logic [ADDR_BIT-1:0] r_row_cnt;
  logic [URAM_LEN-1:0] r_pack;
  logic [ADDR_BIT-1:0] r_wr_addr;
  logic [31:0]         r_loop_number;
  logic                r_s_ready;
  logic                r_wr_en;
  logic                r_start;
  logic                r_busy;
  logic                r_cfg_err;

  logic                w_hs;
  logic                w_row_done;
  logic                w_last_mat;
  logic                w_last_noise;
  logic [ADDR_BIT-1:0] w_row_addr;

  assign w_hs         = s_valid && r_s_ready;
  assign w_row_done   = w_hs && (r_word_cnt == WCNT_W'(WORDS_PER_ROW - 1));
  assign w_last_mat   = (r_row_cnt == ADDR_BIT'(NUM_ROWS - 1));
  assign w_last_noise = ((32'(r_row_cnt) + 32'd1) == r_loop_number);

  always_comb begin
    w_row_addr = r_row_cnt;
    case (r_state)
      S_LD_TH:    w_row_addr = ADDR_BIT'(TH_ADDR);
      S_LD_NOISE: w_row_addr = ADDR_BIT'(NOISE_START_ADDR) + r_row_cnt;
      default:    w_row_addr = r_row_cnt;
    endcase
  end

  // The pack register doubles as wr_data: it holds the complete row during the
  // wr_en cycle, and the next row's first word only lands at the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_word_cnt    <= '0;
      r_row_cnt     <= '0;
      r_pack        <= '0;
      r_wr_addr     <= '0;
      r_loop_number <= '0;
      r_s_ready     <= 1'b0;
      r_wr_en       <= 1'b0;
      r_start       <= 1'b0;
      r_busy        <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_start   <= 1'b0;
      r_cfg_err <= 1'b0;

      if (w_hs) begin
        r_pack[int'(r_word_cnt) * DATABITS +: DATABITS] <= s_data;
        r_word_cnt <= w_row_done ? '0 : r_word_cnt + 1'b1;
      end

      if (w_row_done) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= w_row_addr;
      end

      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            if (load_loop_number > 32'(MAX_LOOPS)) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_loop_number <= load_loop_number;
              r_busy        <= 1'b1;
              r_s_ready     <= 1'b1;
              r_row_cnt     <= '0;
              r_word_cnt    <= '0;
              r_state       <= S_LD_MAT;
            end
          end
        end
        S_LD_MAT: begin
          if (w_row_done) begin
            if (w_last_mat) begin
              r_row_cnt <= '0;
              r_state   <= S_LD_TH;
            end else begin
              r_row_cnt <= r_row_cnt + 1'b1;
            end
          end
        end
        S_LD_TH: begin
          if (w_row_done) begin
            if (r_loop_number != 32'd0) begin
              r_state <= S_LD_NOISE;
            end else begin
              r_s_ready <= 1'b0;
              r_state   <= S_START;
            end
          end
        end
        S_LD_NOISE: begin
          if (w_row_done) begin
            if (w_last_noise) begin
              r_s_ready <= 1'b0;
              r_state   <= S_START;
            end else begin
              r_row_cnt <= r_row_cnt + 1'b1;
            end
          end
        end
        S_START: begin
          r_start <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready           = r_s_ready;
  assign wr_en             = r_wr_en;
  assign wr_addr           = r_wr_addr;
  assign wr_data           = r_pack;
  assign start_computation = r_start;
  assign loop_number       = r_loop_number;
  assign busy              = r_busy;
  assign cfg_err           = r_cfg_err;

endmodule

// File: tb/tb_weight_noise_loader.sv
// Randomised self-checking bench for weight_noise_loader: every row write,
// start pulse and status output is compared against a row/address model.
module tb_weight_noise_loader;

  localparam int DW     = 32;
  localparam int WPR    = 100;
  localparam int ULEN   = 3200;
  localparam int NROWS  = 100;
  localparam int AW     = 11;
  localparam int THA    = 1024;
  localparam int NSA    = 1025;

  logic            clk;
  logic            rst_n;
  logic            load_start;
  logic [31:0]     load_loop_number;
  logic [DW-1:0]   s_data;
  logic            s_valid;
  logic            s_ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [ULEN-1:0] wr_data;
  logic            start_computation;
  logic [31:0]     loop_number;
  logic            busy;
  logic            cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  weight_noise_loader dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_start        (load_start),
    .load_loop_number  (load_loop_number),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .start_computation (start_computation),
    .loop_number       (loop_number),
    .busy              (busy),
    .cfg_err           (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Row j of a session: weights 0..NROWS-1, then threshold, then noise rows.
  function automatic int exp_addr(input int row);
    if (row < NROWS) return row;
    if (row == NROWS) return THA;
    return NSA + row - NROWS - 1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_start"}, start_computation, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_s_ready"}, s_ready, 0);
  endtask

  // gap: 0 = always valid, 1 = valid 1 cycle in 3, 2 = random ~75% valid.
  // inj_at: word index at which a stray load_start (loop 7) is pulsed, -1 none.
  // abort_at: word count after which rst_n is pulled low, 0 none.
  task automatic run_session(input int L, input int gap, input bit rnd,
                             input int inj_at, input int abort_at);
    int total_rows, total, idx, rows_wr, cyc, vcnt, budget;
    bit exp_wr, exp_start, done, hs, injected, aborted;
    logic [31:0] data [];
    total_rows = NROWS + 1 + L;
    total      = total_rows * WPR;
    budget     = total * 4 + 200;
    data       = new[total];
    foreach (data[i]) data[i] = rnd ? $urandom : i;
    idx = 0; rows_wr = 0; cyc = 0; vcnt = 0;
    exp_wr = 0; exp_start = 0; done = 0; injected = 0; aborted = 0;
    $display("session: loop_number=%0d gap_mode=%0d random=%0d rows=%0d", L, gap, rnd, total_rows);

    @(posedge clk); #1;
    load_start = 1'b1; load_loop_number = L;
    @(posedge clk); #1;
    load_start = 1'b0;
    s_valid = 1'b1; s_data = data[0];
    vcnt = 1;

    while (!done && cyc < budget) begin
      @(negedge clk);
      hs = s_valid && s_ready;
      check("s_ready", s_ready, idx < total);
      check("wr_en", wr_en, exp_wr);
      if (wr_en && exp_wr) begin
        check("wr_addr", wr_addr, exp_addr(rows_wr));
        for (int k = 0; k < WPR; k++)
          check("wr_word", wr_data[k*DW +: DW], data[rows_wr*WPR + k]);
        $display("row %0d written at addr %0d", rows_wr, wr_addr);
        rows_wr++;
      end
      check("start", start_computation, exp_start);
      check("busy", busy, !exp_start);
      check("cfg_err", cfg_err, 0);
      if (exp_start) done = 1;
      exp_start = wr_en && exp_wr && (rows_wr == total_rows);
      exp_wr    = hs && ((idx + 1) % WPR == 0);
      if (hs) idx++;
      cyc++;

      @(posedge clk); #1;
      if (abort_at > 0 && idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst");
        check("rst_cfg_err", cfg_err, 0);
        check("rst_loop_number", loop_number, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data_nonzero", |wr_data, 0);
        s_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        aborted = 1;
        $display("reset applied after %0d words", idx);
        break;
      end
      load_start = 1'b0;
      if (!injected && inj_at >= 0 && idx == inj_at) begin
        load_start = 1'b1; load_loop_number = 7; injected = 1;
      end
      case (gap)
        0:       s_valid = 1'b1;
        1:       s_valid = (vcnt % 3 == 0);
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      vcnt++;
      if (idx >= total) s_valid = 1'b1;
      s_data = (idx < total) ? data[idx] : 32'hDEAD_BEEF;
    end

    if (!aborted) begin
      check("session_done", done, 1);
      check("rows_written", rows_wr, total_rows);
      check("loop_number", loop_number, L);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check_idle_outputs("post");
      end
      $display("session done: %0d rows, start pulse seen=%0d", rows_wr, done);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load_start = 1'b0;
    load_loop_number = '0;
    s_data = '0;
    s_valid = 1'b0;
    #2;
    check_idle_outputs("reset");
    check("reset_cfg_err", cfg_err, 0);
    check("reset_loop_number", loop_number, 0);
    check("reset_wr_data_nonzero", |wr_data, 0);
    #15 rst_n = 1'b1;

    // Full load, word n = n, with a stray load_start during the weight rows.
    run_session(3, 0, 1'b0, 250, 0);

    // Out-of-range loop count is rejected with a single-cycle cfg_err.
    @(posedge clk); #1;
    load_start = 1'b1; load_loop_number = 1024; s_valid = 1'b1; s_data = 32'h1234;
    @(posedge clk); #1;
    load_start = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", cfg_err, 1);
    check_idle_outputs("cfg");
    check("cfg_loop_number", loop_number, 3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("cfg_err_after", cfg_err, 0);
      check_idle_outputs("cfg_after");
    end
    $display("cfg_err test: load_loop_number=1024 rejected");
    @(posedge clk); #1;
    s_valid = 1'b0;

    // Backpressure: valid one cycle in three, same data and addresses.
    run_session(3, 1, 1'b0, -1, 0);

    // Reset after 50 words of row 5, then a fresh random session with no noise rows.
    run_session(3, 0, 1'b0, -1, 5 * WPR + 50);
    run_session(0, 2, 1'b1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
